// File: rtl/prco_alu_stage.sv
// prco_alu_stage: execute stage fed by the register set.
// Single-cycle ALU plus an FSM for iterative multiply and shifts.
module prco_alu_stage #(
  parameter int DATA_W     = 16,
  parameter int SEL_W      = 3,
  parameter int ITER_SHIFT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_ce,
  input  logic [3:0]        i_op,
  input  logic [SEL_W-1:0]  i_rd,
  input  logic              i_use_imm,
  input  logic [7:0]        i_imm,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_datb,
  output logic              q_we,
  output logic [SEL_W-1:0]  q_seld,
  output logic [DATA_W-1:0] q_datd,
  output logic              q_ce_done,
  output logic              q_busy,
  output logic [3:0]        q_flags
);

  localparam int W  = DATA_W;
  localparam int AW = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_ASR = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_MOV = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [3:0]       op_q, op_d;
  logic [SEL_W-1:0] rd_q, rd_d;
  logic [W-1:0]     a_q, a_d;
  logic [2*W-1:0]   p_q, p_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [W-1:0]     datd_q, datd_d;
  logic [SEL_W-1:0] seld_q, seld_d;
  logic [3:0]       flags_q, flags_d;

  logic [W-1:0]  opb;
  logic [AW-1:0] amt;
  logic          is_mul, is_sh;
  logic          go_exec, start, last, fin;

  assign opb    = i_use_imm ? W'(i_imm) : i_datb;
  assign amt    = opb[AW-1:0];
  assign is_mul = (i_op == OP_MUL);
  assign is_sh  = (i_op == OP_SHL) | (i_op == OP_SHR) |
                  (i_op == OP_ASR);
  assign go_exec = is_mul |
                   (is_sh & (ITER_SHIFT != 0) & (amt != '0));
  assign start  = (state_q == S_IDLE) & i_ce;
  assign last   = (state_q == S_EXEC) & (cnt_q == '0);
  assign fin    = (start & ~go_exec) | last;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_ce) state_d = go_exec ? S_EXEC : S_DONE;
      S_EXEC: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    q_ce_done = (state_q == S_DONE);
    q_busy    = (state_q != S_IDLE);
    q_we      = (state_q == S_DONE) & we_q;
  end

  assign q_datd  = datd_q;
  assign q_seld  = seld_q;
  assign q_flags = flags_q;

  logic [W:0]   add_x, sub_x, shl_x, shr_x, asr_x;
  logic [W-1:0] s_res;
  logic         s_c, s_v, s_we, s_zn, s_cv;

  // Shifts use a 1-bit extension to expose the last bit shifted out.
  always_comb begin
    add_x = {1'b0, i_data} + {1'b0, opb};
    sub_x = {1'b0, i_data} - {1'b0, opb};
    shl_x = {1'b0, i_data} << amt;
    shr_x = {i_data, 1'b0} >> amt;
    asr_x = $signed({i_data, 1'b0}) >>> amt;
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_we  = 1'b1;
    s_zn  = 1'b1;
    s_cv  = 1'b1;
    case (i_op)
      OP_ADD: begin
        s_res = add_x[W-1:0];
        s_c   = add_x[W];
        s_v   = (i_data[W-1] == opb[W-1]) &
                (add_x[W-1] != i_data[W-1]);
      end
      OP_SUB, OP_CMP: begin
        s_res = sub_x[W-1:0];
        s_c   = sub_x[W];
        s_v   = (i_data[W-1] != opb[W-1]) &
                (sub_x[W-1] != i_data[W-1]);
        s_we  = (i_op == OP_SUB);
      end
      OP_AND: s_res = i_data & opb;
      OP_OR:  s_res = i_data | opb;
      OP_XOR: s_res = i_data ^ opb;
      OP_SHL: begin
        s_res = shl_x[W-1:0];
        s_c   = shl_x[W];
      end
      OP_SHR: begin
        s_res = shr_x[W:1];
        s_c   = shr_x[0];
      end
      OP_ASR: begin
        s_res = asr_x[W:1];
        s_c   = asr_x[0];
      end
      OP_MOV: begin
        s_res = opb;
        s_cv  = 1'b0;
      end
      OP_MUL: s_res = '0;
      default: begin
        s_we = 1'b0;
        s_zn = 1'b0;
        s_cv = 1'b0;
      end
    endcase
  end

  logic [W:0]     sum;
  logic [2*W-1:0] p_nx;
  logic [W-1:0]   x_a, x_res;
  logic           x_c, x_cm;

  // One shift-add multiplier step, or one 1-bit shift.
  always_comb begin
    sum  = {1'b0, p_q[2*W-1:W]} +
           (p_q[0] ? {1'b0, a_q} : '0);
    p_nx = {sum, p_q[W-1:1]};
    x_a  = a_q;
    x_c  = 1'b0;
    case (op_q)
      OP_SHL: begin
        x_a = {a_q[W-2:0], 1'b0};
        x_c = a_q[W-1];
      end
      OP_SHR: begin
        x_a = {1'b0, a_q[W-1:1]};
        x_c = a_q[0];
      end
      OP_ASR: begin
        x_a = {a_q[W-1], a_q[W-1:1]};
        x_c = a_q[0];
      end
      default: ;
    endcase
    x_res = (op_q == OP_MUL) ? p_nx[W-1:0] : x_a;
    x_cm  = (op_q == OP_MUL) ? |p_nx[2*W-1:W] : x_c;
  end

  logic [W-1:0]     f_res;
  logic [SEL_W-1:0] f_rd;
  logic             f_c, f_v, f_we, f_zn, f_cv;

  always_comb begin
    f_res = s_res;
    f_rd  = i_rd;
    f_c   = s_c;
    f_v   = s_v;
    f_we  = s_we;
    f_zn  = s_zn;
    f_cv  = s_cv;
    if (state_q == S_EXEC) begin
      f_res = x_res;
      f_rd  = rd_q;
      f_c   = x_cm;
      f_v   = 1'b0;
      f_we  = 1'b1;
      f_zn  = 1'b1;
      f_cv  = 1'b1;
    end
  end

  always_comb begin
    op_d    = op_q;
    rd_d    = rd_q;
    a_d     = a_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    datd_d  = datd_q;
    seld_d  = seld_q;
    flags_d = flags_q;
    if (start) begin
      op_d  = i_op;
      rd_d  = i_rd;
      a_d   = i_data;
      p_d   = {{W{1'b0}}, opb};
      cnt_d = is_mul ? AW'(W - 1) : amt - 1'b1;
    end
    if (state_q == S_EXEC) begin
      a_d   = x_a;
      p_d   = p_nx;
      cnt_d = cnt_q - 1'b1;
    end
    if (fin) begin
      we_d = f_we;
      if (f_we) begin
        datd_d = f_res;
        seld_d = f_rd;
      end
      if (f_zn) flags_d[3:2] = {f_res == '0, f_res[W-1]};
      if (f_cv) flags_d[1:0] = {f_c, f_v};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      datd_q  <= '0;
      seld_q  <= '0;
      flags_q <= '0;
    end else begin
      op_q    <= op_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      datd_q  <= datd_d;
      seld_q  <= seld_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_prco_alu_stage.sv
// tb_prco_alu_stage: directed vectors for prco_alu_stage.
// Latency, write-back, flags, busy and reset-abort.
module tb_prco_alu_stage;

  logic        clk;
  logic        rst_n;
  logic        i_ce;
  logic [3:0]  i_op;
  logic [2:0]  i_rd;
  logic        i_use_imm;
  logic [7:0]  i_imm;
  logic [15:0] i_data;
  logic [15:0] i_datb;
  logic        q_we;
  logic [2:0]  q_seld;
  logic [15:0] q_datd;
  logic        q_ce_done;
  logic        q_busy;
  logic [3:0]  q_flags;

  int n_chk = 0;
  int n_err = 0;

  prco_alu_stage #(
    .DATA_W(16),
    .SEL_W(3),
    .ITER_SHIFT(1)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_ce(i_ce),
    .i_op(i_op),
    .i_rd(i_rd),
    .i_use_imm(i_use_imm),
    .i_imm(i_imm),
    .i_data(i_data),
    .i_datb(i_datb),
    .q_we(q_we),
    .q_seld(q_seld),
    .q_datd(q_datd),
    .q_ce_done(q_ce_done),
    .q_busy(q_busy),
    .q_flags(q_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [2:0] rd,
                       input logic ui,
                       input logic [7:0] imm);
    @(negedge clk);
    i_ce = 1'b1;
    i_op = op;
    i_data = a;
    i_datb = b;
    i_rd = rd;
    i_use_imm = ui;
    i_imm = imm;
    @(negedge clk);
    i_ce = 1'b0;
    i_op = 4'h0;
    i_data = 16'hDEAD;
    i_datb = 16'hBEEF;
    i_imm = 8'hA5;
    i_rd = 3'd0;
    i_use_imm = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n = 1;
    while (q_ce_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  task automatic post_done(input string tag,
                           input logic [15:0] dat,
                           input logic [2:0] sel);
    @(negedge clk);
    check({tag, " done_low"}, 32'(q_ce_done), 0);
    check({tag, " we_low"}, 32'(q_we), 0);
    check({tag, " busy_low"}, 32'(q_busy), 0);
    check({tag, " dat_hold"}, 32'(q_datd), 32'(dat));
    check({tag, " sel_hold"}, 32'(q_seld), 32'(sel));
  endtask

  task automatic run_op(input string tag,
                        input logic [3:0] op,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [2:0] rd,
                        input logic ui,
                        input logic [7:0] imm,
                        input int exp_lat,
                        input logic exp_we,
                        input logic [15:0] dat,
                        input logic [2:0] sel,
                        input logic [3:0] fl);
    int lat;
    issue(op, a, b, rd, ui, imm);
    wait_done(lat);
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " we"}, 32'(q_we), 32'(exp_we));
    check({tag, " busy"}, 32'(q_busy), 1);
    if (exp_we) begin
      check({tag, " dat"}, 32'(q_datd), 32'(dat));
      check({tag, " sel"}, 32'(q_seld), 32'(sel));
    end
    check({tag, " flags"}, 32'(q_flags), 32'(fl));
    post_done(tag, dat, sel);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0;
    i_ce = 1'b0;
    i_op = 4'h0;
    i_rd = 3'd0;
    i_use_imm = 1'b0;
    i_imm = 8'h00;
    i_data = 16'h0;
    i_datb = 16'h0;
    repeat (3) @(negedge clk);
    check("rst we", 32'(q_we), 0);
    check("rst seld", 32'(q_seld), 0);
    check("rst datd", 32'(q_datd), 0);
    check("rst done", 32'(q_ce_done), 0);
    check("rst busy", 32'(q_busy), 0);
    check("rst flags", 32'(q_flags), 0);
    rst_n = 1'b1;

    // flags are {Z,N,C,V}
    run_op("add_ovf", 4'h0, 16'h7FFF, 16'h0001, 3'd1, 0, 8'h00,
           1, 1, 16'h8000, 3'd1, 4'b0101);
    run_op("sub_neg", 4'h1, 16'h0003, 16'h0005, 3'd2, 0, 8'h00,
           1, 1, 16'hFFFE, 3'd2, 4'b0110);
    run_op("cmp_eq", 4'hA, 16'h0005, 16'h0005, 3'd4, 0, 8'h00,
           1, 0, 16'hFFFE, 3'd2, 4'b1000);
    run_op("shl4", 4'h5, 16'h8421, 16'h0004, 3'd3, 0, 8'h00,
           5, 1, 16'h4210, 3'd3, 4'b0000);
    run_op("shl0", 4'h5, 16'h8421, 16'h0000, 3'd3, 0, 8'h00,
           1, 1, 16'h8421, 3'd3, 4'b0100);
    run_op("shr1_hi", 4'h6, 16'h8421, 16'hFFF1, 3'd4, 0, 8'h00,
           2, 1, 16'h4210, 3'd4, 4'b0010);
    run_op("mov0", 4'h9, 16'h1234, 16'h0000, 3'd5, 0, 8'h00,
           1, 1, 16'h0000, 3'd5, 4'b1010);
    run_op("nop", 4'hC, 16'h0001, 16'h0002, 3'd6, 0, 8'h00,
           1, 0, 16'h0000, 3'd5, 4'b1010);
    run_op("asr15", 4'h7, 16'h8000, 16'h000F, 3'd6, 0, 8'h00,
           16, 1, 16'hFFFF, 3'd6, 4'b0100);
    run_op("and", 4'h2, 16'hF0F0, 16'hFF00, 3'd1, 0, 8'h00,
           1, 1, 16'hF000, 3'd1, 4'b0100);
    run_op("or_imm", 4'h3, 16'h1200, 16'hFFFF, 3'd2, 1, 8'h34,
           1, 1, 16'h1234, 3'd2, 4'b0000);
    run_op("xor_z", 4'h4, 16'hAAAA, 16'hAAAA, 3'd3, 0, 8'h00,
           1, 1, 16'h0000, 3'd3, 4'b1000);
    run_op("add_wrap", 4'h0, 16'hFFFF, 16'h0001, 3'd4, 0, 8'h00,
           1, 1, 16'h0000, 3'd4, 4'b1010);

    // MUL with a stray i_ce at N+5 that must be ignored
    issue(4'h8, 16'h0123, 16'h0100, 3'd3, 0, 8'h00);
    check("mul busy n1", 32'(q_busy), 1);
    repeat (4) @(negedge clk);
    check("mul busy n5", 32'(q_busy), 1);
    i_ce = 1'b1;
    i_op = 4'h0;
    i_data = 16'h0001;
    i_datb = 16'h0001;
    i_rd = 3'd7;
    @(negedge clk);
    i_ce = 1'b0;
    check("mul busy n6", 32'(q_busy), 1);
    wait_done(lat);
    check("mul lat", 32'(lat + 5), 17);
    check("mul we", 32'(q_we), 1);
    check("mul busy", 32'(q_busy), 1);
    check("mul dat", 32'(q_datd), 32'h2300);
    check("mul sel", 32'(q_seld), 3);
    check("mul flags", 32'(q_flags), 32'b0010);
    post_done("mul", 16'h2300, 3'd3);

    run_op("mul_ff", 4'h8, 16'hFFFF, 16'hFFFF, 3'd7, 0, 8'h00,
           17, 1, 16'h0001, 3'd7, 4'b0010);

    // reset in the middle of a multiply
    issue(4'h8, 16'h0003, 16'h0003, 3'd5, 0, 8'h00);
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort we", 32'(q_we), 0);
    check("abort seld", 32'(q_seld), 0);
    check("abort datd", 32'(q_datd), 0);
    check("abort done", 32'(q_ce_done), 0);
    check("abort busy", 32'(q_busy), 0);
    check("abort flags", 32'(q_flags), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (q_ce_done === 1'b1 || q_we === 1'b1) seen++;
    end
    check("abort no_wb", 32'(seen), 0);
    run_op("add_after", 4'h0, 16'h0001, 16'h0001, 3'd1, 0, 8'h00,
           1, 1, 16'h0002, 3'd1, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
